// File: rtl/decim_pkg.sv
// Shared types and defaults for the decimate_n block.
// DECIMATE_N_AVG_EN (see decimate_n) selects whether the averaging path exists.
package decim_pkg;

  typedef enum logic {
    PICK = 1'b0,
    AVG  = 1'b1
  } mode_e;

  localparam int DEF_DW       = 8;
  localparam int DEF_MAX_LOG2 = 4;

  function automatic int lw(input int max_log2);
    return $clog2(max_log2 + 1);
  endfunction

endpackage

// File: rtl/decim_phase_cnt.sv
// Phase counter for decimate_n: counts accepted samples, flags the block's last sample
// and latches ratio/mode at the first sample so mid-block changes wait for the next block.
module decim_phase_cnt
  import decim_pkg::*;
#(
  parameter int MAX_LOG2 = DEF_MAX_LOG2,
  parameter int LW       = lw(MAX_LOG2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          x_valid,
  input  logic [LW-1:0] ratio_log2,
  input  mode_e         mode,
  output logic          accept,
  output logic          last,
  output logic [LW-1:0] eff_ratio,
  output mode_e         eff_mode
);

  localparam int PW = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

  logic [PW-1:0] phase;
  logic [LW-1:0] act_ratio;
  mode_e         act_mode;
  logic [LW-1:0] clamped;
  logic [PW:0]   r_full;
  logic          at_start;

  // At phase 0 the incoming configuration applies immediately, so R=1 completes on the first sample.
  assign clamped   = (ratio_log2 > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : ratio_log2;
  assign at_start  = (phase == '0);
  assign eff_ratio = at_start ? clamped : act_ratio;
  assign eff_mode  = at_start ? mode : act_mode;
  assign accept    = x_valid && !clear;
  assign r_full    = (PW + 1)'(1) << eff_ratio;
  assign last      = accept && (phase == PW'(r_full - 1'b1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= '0;
      act_ratio <= '0;
      act_mode  <= PICK;
    end else if (clear) begin
      phase <= '0;
    end else if (accept) begin
      if (at_start) begin
        act_ratio <= clamped;
        act_mode  <= mode;
      end
      phase <= last ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/decimate_n.sv
// Decimate-by-2^ratio_log2 with pick or (when DECIMATE_N_AVG_EN is defined) average mode.
// Without DECIMATE_N_AVG_EN there is no accumulator and mode is ignored.
module decimate_n
  import decim_pkg::*;
#(
  parameter  int DW       = DEF_DW,
  parameter  int MAX_LOG2 = DEF_MAX_LOG2,
  localparam int LW       = lw(MAX_LOG2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 x_valid,
  input  logic signed [DW-1:0] x,
  input  logic        [LW-1:0] ratio_log2,
  input  logic                 mode,
  output logic signed [DW-1:0] y,
  output logic                 y_valid
);

  logic          accept;
  logic          last;
  logic [LW-1:0] eff_ratio;
  mode_e         eff_mode;
  mode_e         mode_sel;

`ifdef DECIMATE_N_AVG_EN
  assign mode_sel = mode_e'(mode);
`else
  assign mode_sel = PICK;
`endif

  decim_phase_cnt #(
    .MAX_LOG2 (MAX_LOG2),
    .LW       (LW)
  ) u_phase (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .x_valid    (x_valid),
    .ratio_log2 (ratio_log2),
    .mode       (mode_sel),
    .accept     (accept),
    .last       (last),
    .eff_ratio  (eff_ratio),
    .eff_mode   (eff_mode)
  );

`ifdef DECIMATE_N_AVG_EN
  localparam int AW = DW + MAX_LOG2;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic signed [DW-1:0] avg;

  // Arithmetic shift of the full-width sum gives floor rounding toward -infinity.
  assign sum = acc + AW'(x);
  assign avg = DW'(sum >>> eff_ratio);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (accept) begin
      acc <= last ? '0 : sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= last;
      if (last) begin
        y <= (eff_mode == AVG) ? avg : x;
      end
    end
  end
`else
  logic unused_sigs;
  assign unused_sigs = ^{mode, eff_mode, accept, eff_ratio};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= last;
      if (last) begin
        y <= x;
      end
    end
  end
`endif

endmodule

// File: tb/tb_decimate_n.sv
// Self-checking bench for decimate_n: directed scenarios plus randomized traffic
// compared every cycle against a block-level reference model.
module tb_decimate_n;

`ifdef DECIMATE_N_AVG_EN
  localparam bit AVG_ON = 1'b1;
`else
  localparam bit AVG_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              x_valid;
  logic signed [7:0] x;
  logic [2:0]        ratio_log2;
  logic              mode;
  logic signed [7:0] y;
  logic              y_valid;

  int tests = 0;
  int fails = 0;
  int got[$];

  // Reference model state: samples of the open block and the expected outputs.
  int blk[$];
  int blk_r;
  bit blk_avg;
  int m_y = 0;
  int m_v = 0;

  decimate_n dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .x_valid    (x_valid),
    .x          (x),
    .ratio_log2 (ratio_log2),
    .mode       (mode),
    .y          (y),
    .y_valid    (y_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Block-level model: collect R accepted samples, then emit the last one or the floored mean.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk.delete();
      m_y = 0;
      m_v = 0;
    end else begin
      m_v = 0;
      if (clear) begin
        blk.delete();
      end else if (x_valid) begin
        if (blk.size() == 0) begin
          blk_r   = (ratio_log2 > 3'd4) ? 4 : int'(ratio_log2);
          blk_avg = AVG_ON && mode;
        end
        blk.push_back(int'(x));
        if (blk.size() == (1 << blk_r)) begin
          if (blk_avg) begin
            int s;
            int quo;
            s = 0;
            foreach (blk[i]) s += blk[i];
            quo = s / (1 << blk_r);
            if ((s % (1 << blk_r) != 0) && (s < 0)) quo = quo - 1;
            m_y = quo;
          end else begin
            m_y = blk[blk.size() - 1];
          end
          m_v = 1;
          blk.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    check("y_valid", int'(y_valid), m_v);
    check("y", int'(y), m_y);
    if (y_valid) got.push_back(int'(y));
  end

  // Inputs change 1 time unit after the rising edge and are held for one cycle.
  task automatic applyStimulus(input bit v, input int xv);
    x_valid = v;
    x       = xv[7:0];
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic restart();
    clear   = 1'b1;
    x_valid = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    got.delete();
  endtask

  task automatic checkOutput(input string name, input int n,
                             input int e0 = 0, input int e1 = 0, input int e2 = 0);
    int e[3];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    check({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      check($sformatf("%s_y%0d", name, i), got[i], e[i]);
    end
  endtask

  initial begin
    reset      = 1'b0;
    clear      = 1'b0;
    x_valid    = 1'b0;
    x          = '0;
    ratio_log2 = '0;
    mode       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_y", int'(y), 0);
    check("reset_y_valid", int'(y_valid), 0);
    reset = 1'b1;

    // Continuous pick, R=4.
    restart();
    ratio_log2 = 3'd2;
    mode       = 1'b0;
    for (int i = 1; i <= 12; i++) applyStimulus(1'b1, i);
    repeat (2) applyStimulus(1'b0, 0);
    checkOutput("pick_r4", 3, 4, 8, 12);

    // Average with negative floor, then a constant block.
    restart();
    ratio_log2 = 3'd2;
    mode       = 1'b1;
    applyStimulus(1'b1, -3);
    applyStimulus(1'b1, -2);
    applyStimulus(1'b1, -1);
    applyStimulus(1'b1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4);
    repeat (2) applyStimulus(1'b0, 0);
`ifdef DECIMATE_N_AVG_EN
    checkOutput("avg_r4", 2, -2, 4);
`else
    checkOutput("avg_r4_pick", 2, 0, 4);
`endif

    // Gapped valid: idle cycles do not advance the phase.
    restart();
    mode = 1'b0;
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b1, 40);
    repeat (2) applyStimulus(1'b0, 0);
    checkOutput("gapped", 1, 40);

    // Ratio change after the first sample waits for the next block.
    restart();
    ratio_log2 = 3'd1;
    applyStimulus(1'b1, 1);
    ratio_log2 = 3'd3;
    for (int i = 2; i <= 10; i++) applyStimulus(1'b1, i);
    repeat (2) applyStimulus(1'b0, 0);
    checkOutput("ratio_change", 2, 2, 10);

    // Reset mid-block discards the partial block.
    restart();
    ratio_log2 = 3'd2;
    applyStimulus(1'b1, 1);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b1, 3);
    reset = 1'b0;
    #2;
    check("mid_reset_y", int'(y), 0);
    check("mid_reset_y_valid", int'(y_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    got.delete();
    for (int i = 5; i <= 8; i++) applyStimulus(1'b1, i);
    repeat (2) applyStimulus(1'b0, 0);
    checkOutput("after_reset", 1, 8);

    // Clear with a sample discards it and restarts the block.
    restart();
    ratio_log2 = 3'd1;
    applyStimulus(1'b1, 11);
    clear = 1'b1;
    applyStimulus(1'b1, 12);
    clear = 1'b0;
    applyStimulus(1'b1, 13);
    applyStimulus(1'b1, 14);
    repeat (2) applyStimulus(1'b0, 0);
    checkOutput("clear", 1, 14);

    // R=1 passes every sample through in either mode.
    restart();
    ratio_log2 = 3'd0;
    mode       = 1'b1;
    applyStimulus(1'b1, -5);
    applyStimulus(1'b1, 7);
    repeat (2) applyStimulus(1'b0, 0);
    checkOutput("r1", 2, -5, 7);

    // Randomized traffic including clamped ratios, clears and resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) ratio_log2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 199) == 0) reset = 1'b0;
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128);
      clear = 1'b0;
      reset = 1'b1;
    end
    repeat (3) applyStimulus(1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
